// File: rtl/mul4_pipe.sv
// mul4_pipe: 4x4 unsigned multiplier, AND-array partial products
// reduced by three 4-bit carry-lookahead rows, registered in and out.

module mul4_cla4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] t;
    logic [3:0] c;

    assign g = x & y;
    assign t = x ^ y;

    // Carries are fully expanded so no ripple path exists inside a row.
    assign c[0] = cin;
    assign c[1] = g[0] | (t[0] & cin);
    assign c[2] = g[1] | (t[1] & g[0]) | (t[1] & t[0] & cin);
    assign c[3] = g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0])
                | (t[2] & t[1] & t[0] & cin);
    assign cout = g[3] | (t[3] & g[2]) | (t[3] & t[2] & g[1])
                | (t[3] & t[2] & t[1] & g[0])
                | (t[3] & t[2] & t[1] & t[0] & cin);

    assign s = t ^ c;

endmodule

module mul4_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p,
    output logic       out_valid
);

    logic [3:0] ra;
    logic [3:0] rb;
    logic       v1;

    logic [3:0] pp0;
    logic [3:0] pp1;
    logic [3:0] pp2;
    logic [3:0] pp3;

    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       c0;
    logic       c1;
    logic       c2;
    logic [7:0] prod;

    // Stage 1: operands load only with a valid strobe, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= 4'h0;
            rb <= 4'h0;
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                ra <= a;
                rb <= b;
            end
        end
    end

    // Row i of the AND array is ra weighted by rb[i].
    assign pp0 = ra & {4{rb[0]}};
    assign pp1 = ra & {4{rb[1]}};
    assign pp2 = ra & {4{rb[2]}};
    assign pp3 = ra & {4{rb[3]}};

    // Each row retires its sum LSB as one product bit and shifts
    // the remaining sum plus carry down into the next row.
    mul4_cla4 u_row0 (
        .x    ({1'b0, pp0[3:1]}),
        .y    (pp1),
        .cin  (1'b0),
        .s    (s0),
        .cout (c0)
    );

    mul4_cla4 u_row1 (
        .x    ({c0, s0[3:1]}),
        .y    (pp2),
        .cin  (1'b0),
        .s    (s1),
        .cout (c1)
    );

    mul4_cla4 u_row2 (
        .x    ({c1, s1[3:1]}),
        .y    (pp3),
        .cin  (1'b0),
        .s    (s2),
        .cout (c2)
    );

    assign prod = {c2, s2, s1[0], s0[0], pp0[0]};

    // Stage 2: publish a new product only behind a valid stage-1 slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                p <= prod;
            end
        end
    end

endmodule

// File: tb/tb_mul4_pipe.sv
// tb_mul4_pipe: directed and exhaustive checks of mul4_pipe
// against a queue of expected products.

module tb_mul4_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic [7:0] p;
    logic       out_valid;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       h0 = 1'b0;
    logic       h1 = 1'b0;
    logic [7:0] last_p = 8'h00;

    mul4_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .p         (p),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Check the output for this cycle, then present the next operands.
    task automatic step(input logic v, input logic [3:0] na,
                        input logic [3:0] nb);
        logic [7:0] e;
        @(negedge clk);
        chk("out_valid", {7'b0, out_valid}, {7'b0, h1});
        if (out_valid === 1'b1) begin
            chk("q_nonempty", {7'b0, exp_q.size() != 0}, 8'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                last_p = e;
                chk("p", p, e);
            end
        end else begin
            chk("p_hold", p, last_p);
        end
        h1 = h0;
        h0 = v;
        in_valid = v;
        a = na;
        b = nb;
        if (v) begin
            e = {4'h0, na} * {4'h0, nb};
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        h0 = 1'b0;
        h1 = 1'b0;
        last_p = 8'h00;
    endtask

    initial begin
        logic [7:0] ab;

        // Power-on reset, checked before any clock edge acts.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_p", p, 8'h00);
        chk("rst_valid", {7'b0, out_valid}, 8'h00);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Zero product, single pulse, then hold.
        step(1'b1, 4'd15, 4'd0);
        repeat (4) step(1'b0, 4'd0, 4'd0);

        // Corner products back to back.
        step(1'b1, 4'd15, 4'd15);
        step(1'b1, 4'd1, 4'd15);
        step(1'b1, 4'd0, 4'd0);
        repeat (3) step(1'b0, 4'd0, 4'd0);

        // Exhaustive stream.
        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            step(1'b1, ab[7:4], ab[3:0]);
        end
        repeat (3) step(1'b0, 4'd0, 4'd0);

        // Bubbles with garbage operands.
        step(1'b1, 4'd7, 4'd9);
        step(1'b0, 4'd5, 4'd14);
        step(1'b1, 4'd12, 4'd13);
        step(1'b0, 4'd3, 4'd3);
        step(1'b0, 4'd15, 4'd1);
        step(1'b0, 4'd2, 4'd11);

        // Hold without valid after 10*11.
        step(1'b1, 4'd10, 4'd11);
        repeat (2) step(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'($urandom), 4'($urandom));
        end
        chk("hold_110", p, 8'd110);

        // Asynchronous reset between capture and result edges.
        step(1'b1, 4'd15, 4'd15);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_p", p, 8'h00);
        chk("arst_valid", {7'b0, out_valid}, 8'h00);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 4'd9, 4'd9);

        // Pipeline still works after the reset.
        step(1'b1, 4'd13, 4'd11);
        repeat (3) step(1'b0, 4'd0, 4'd0);

        chk("q_empty", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
